pe_array_seq: RTL

PE_ARRAY_SEQ -- requirements
Module: pe_array_seq

---
 rtl/nmcu_pkg.sv | 26 ++
 rtl/skew_delay_line.sv | 32 +++
 rtl/pe_array_seq.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/nmcu_pkg.sv
// Shared constants and types for the near-memory compute unit.
// Holds the default PE array geometry, the reduction-length counter width
// and the state type used by the PE array sequencer.
package nmcu_pkg;

   localparam int DATA_WIDTH     = 8;
   localparam int PE_ROWS        = 4;
   localparam int PE_COLS        = 4;
   localparam int K_LEN_WIDTH    = 8;
   localparam int PERF_CNT_WIDTH = 32;

   typedef enum logic [1:0] {
      PE_SEQ_IDLE  = 2'd0,
      PE_SEQ_FEED  = 2'd1,
      PE_SEQ_DRAIN = 2'd2,
      PE_SEQ_DONE  = 2'd3
   } pe_seq_state_t;

   // Number of cycles the skewed wavefront needs to clear the whole array
   // after the last beat has entered the skew lines.
   function automatic int unsigned drainCycles(input int unsigned rows,
                                                input int unsigned cols);
      return rows + cols;
   endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register used to skew one operand lane of the PE array.
// Every stage clears to zero on reset so the array sees zero data and
// cleared accumulate flags while the sequencer is held in reset.
module skew_delay_line
   import nmcu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [DEPTH-1:0][WIDTH-1:0] stage_q;

   // Shift the lane one stage per clock; stage 0 takes the new sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q <= '0;
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/pe_array_seq.sv
// Operand sequencer for an output-stationary systolic PE array.
// Accepts one A column and one B row per beat through a joint valid/ready
// handshake, skews lane r of A (with its accumulate flag) by 1+r cycles and
// lane c of B by 1+c cycles, inserts zero bubbles when the producer stalls,
// and pulses done_o once the last beat has propagated through the array.
// Optional feature: define PE_ARRAY_SEQ_PERF_CNT_EN to add saturating
// busy-cycle and bubble counters (perf_busy_cnt_o / perf_stall_cnt_o).
module pe_array_seq
   import nmcu_pkg::*;
#(
   parameter int DATA_WIDTH = nmcu_pkg::DATA_WIDTH,
   parameter int ROWS       = nmcu_pkg::PE_ROWS,
   parameter int COLS       = nmcu_pkg::PE_COLS,
   parameter int K_W        = nmcu_pkg::K_LEN_WIDTH
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start_i,
   input  logic [K_W-1:0]                  k_len_i,
   input  logic                            a_valid_i,
   output logic                            a_ready_o,
   input  logic [ROWS-1:0][DATA_WIDTH-1:0] a_data_i,
   input  logic                            b_valid_i,
   output logic                            b_ready_o,
   input  logic [COLS-1:0][DATA_WIDTH-1:0] b_data_i,
   output logic [ROWS-1:0][DATA_WIDTH-1:0] operand_a_o,
   output logic [COLS-1:0][DATA_WIDTH-1:0] operand_b_o,
   output logic [ROWS-1:0]                 accum_en_o,
   output logic                            busy_o,
   output logic                            done_o
`ifdef PE_ARRAY_SEQ_PERF_CNT_EN
   ,
   output logic [PERF_CNT_WIDTH-1:0]       perf_busy_cnt_o,
   output logic [PERF_CNT_WIDTH-1:0]       perf_stall_cnt_o
`endif
);

   localparam int DRAIN_LEN = int'(drainCycles(ROWS, COLS));
   localparam int DRAIN_W   = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_LEN - 1);

   pe_seq_state_t state_q, state_d;
   logic [K_W-1:0]     kLen_q, kLen_d;
   logic [K_W-1:0]     beatCnt_q, beatCnt_d;
   logic [DRAIN_W-1:0] drainCnt_q, drainCnt_d;

   logic                            beatFire;
   logic                            skewAFlag;
   logic [ROWS-1:0][DATA_WIDTH-1:0] skewAData;
   logic [COLS-1:0][DATA_WIDTH-1:0] skewBData;

   // A beat moves only when both operands are offered while feeding; the
   // same strobe is returned as ready so neither side is consumed alone.
   always_comb begin
      beatFire = (state_q == PE_SEQ_FEED) && a_valid_i && b_valid_i;
   end

   assign a_ready_o = beatFire;
   assign b_ready_o = beatFire;

   // Skew-line inputs: real data only on a fired beat, otherwise a zero
   // bubble that accumulates (adds nothing). The first beat of a tile
   // carries a cleared flag so every PE restarts its partial sum.
   always_comb begin
      skewAFlag = 1'b1;
      skewAData = '0;
      skewBData = '0;
      if (beatFire) begin
         skewAFlag = (beatCnt_q != '0);
         skewAData = a_data_i;
         skewBData = b_data_i;
      end
   end

   // Next-state logic: capture the reduction depth on start, count beats
   // while feeding, then hold off done until the wavefront has drained.
   always_comb begin
      state_d    = state_q;
      kLen_d     = kLen_q;
      beatCnt_d  = beatCnt_q;
      drainCnt_d = drainCnt_q;
      case (state_q)
         PE_SEQ_IDLE: begin
            if (start_i) begin
               kLen_d    = k_len_i;
               beatCnt_d = '0;
               state_d   = (k_len_i == '0) ? PE_SEQ_DONE : PE_SEQ_FEED;
            end
         end
         PE_SEQ_FEED: begin
            if (beatFire) begin
               beatCnt_d = beatCnt_q + K_W'(1);
               if ((beatCnt_q + K_W'(1)) == kLen_q) begin
                  state_d    = PE_SEQ_DRAIN;
                  drainCnt_d = '0;
               end
            end
         end
         PE_SEQ_DRAIN: begin
            if (drainCnt_q == DRAIN_LAST) begin
               state_d = PE_SEQ_DONE;
            end else begin
               drainCnt_d = drainCnt_q + DRAIN_W'(1);
            end
         end
         PE_SEQ_DONE: begin
            state_d = PE_SEQ_IDLE;
         end
         default: begin
            state_d = PE_SEQ_IDLE;
         end
      endcase
   end

   // Sequencer state and counters; reset aborts any tile in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= PE_SEQ_IDLE;
         kLen_q     <= '0;
         beatCnt_q  <= '0;
         drainCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         kLen_q     <= kLen_d;
         beatCnt_q  <= beatCnt_d;
         drainCnt_q <= drainCnt_d;
      end
   end

   assign busy_o = (state_q != PE_SEQ_IDLE);
   assign done_o = (state_q == PE_SEQ_DONE);

   // Row lanes: A data and its accumulate flag travel together so the flag
   // reaches the left edge of row r in the same cycle as the data.
   for (genvar r = 0; r < ROWS; r++) begin : gLaneA
      logic [DATA_WIDTH:0] laneOut;

      skew_delay_line #(
         .WIDTH (DATA_WIDTH + 1),
         .DEPTH (r + 1)
      ) uSkewA (
         .clk   (clk),
         .rst_n (rst_n),
         .d_i   ({skewAFlag, skewAData[r]}),
         .q_o   (laneOut)
      );

      assign operand_a_o[r] = laneOut[DATA_WIDTH-1:0];
      assign accum_en_o[r]  = laneOut[DATA_WIDTH];
   end

   // Column lanes: B data only, delayed 1+c cycles for column c.
   for (genvar c = 0; c < COLS; c++) begin : gLaneB
      skew_delay_line #(
         .WIDTH (DATA_WIDTH),
         .DEPTH (c + 1)
      ) uSkewB (
         .clk   (clk),
         .rst_n (rst_n),
         .d_i   (skewBData[c]),
         .q_o   (operand_b_o[c])
      );
   end

`ifdef PE_ARRAY_SEQ_PERF_CNT_EN
   logic [PERF_CNT_WIDTH-1:0] perfBusy_q;
   logic [PERF_CNT_WIDTH-1:0] perfStall_q;
   logic                      bubbleCycle;

   assign bubbleCycle = (state_q == PE_SEQ_FEED) && !beatFire;

   // Saturating activity counters; only reset clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perfBusy_q  <= '0;
         perfStall_q <= '0;
      end else begin
         if (busy_o && !(&perfBusy_q)) begin
            perfBusy_q <= perfBusy_q + PERF_CNT_WIDTH'(1);
         end
         if (bubbleCycle && !(&perfStall_q)) begin
            perfStall_q <= perfStall_q + PERF_CNT_WIDTH'(1);
         end
      end
   end

   assign perf_busy_cnt_o  = perfBusy_q;
   assign perf_stall_cnt_o = perfStall_q;
`endif

endmodule
